mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Round-robin request/grant arbiter that shares one 8192×16 word RAM among four requester ports. It replaces the fixed-slot mux's rotating `which` schedule. Port 0 is the SPI debug path and port 3 is the HERA CPU. Ports 1–2 are reserved for peripherals. The CPU clock enable is derived from `rvalid[3]` instead of a free-running slot strobe.

## Interface
Parameters:
- `N_PORTS`, 4: number of requesters.
- `AW`, 13: RAM word-address bits (8192 words).
- `DW`, 16: data width.

Ports:
- `clk` in, 1: clock.
- `rst` in, 1: reset; synchronous, active-high.
- `req` in, N_PORTS: per-port access request. Level; hold until granted.
- `we` in, N_PORTS: 1 = write, 0 = read. Qualified by `req`.
- `addr` in, N_PORTS*16: per-port 16-bit word address. Port p uses bits [16p+15:16p].
- `wdata` in, N_PORTS*DW: per-port write data.
- `gnt` out, N_PORTS: one-hot pulse; the request was accepted this cycle.
- `rvalid` out, N_PORTS: one-hot pulse; the access completed.
- `rdata` out, N_PORTS*DW: per-port read data. Held until that port's next read completes.
- `err` out, N_PORTS: pulses with `rvalid` when the access was out of range.
- `busy` out, 1: high while any `req` is high or an access is in flight.

## Operation
Request handshake:
- Requester drives `req`/`we`/`addr`/`wdata` and holds them stable until it samples `gnt` high.
- `gnt[p]` is only asserted in a cycle where `req[p]` is high.
- The requester may present its next request in the cycle after `gnt` (back-to-back allowed).

Arbitration:
- Combinational search starting at pointer `ptr`, moving upward modulo N_PORTS.
- The first port with `req` high is granted.
- Registered `ptr` <= granted index + 1 (mod N_PORTS). `ptr` is unchanged when nothing is granted.
- At most one grant per cycle.

Access, issued in the grant cycle t:
- In range (`addr[15:AW]` == 0):
  - A write commits to RAM at the end of cycle t.
  - A read samples RAM at the end of cycle t.
- Out of range:
  - No RAM write.
  - Read data is forced to 0.
  - `err[p]` pulses with `rvalid[p]`.

Completion at cycle t+1:
- `rvalid[p]` = 1.
- For reads, `rdata[p]` loads the RAM word (or 0 if out of range).
- For writes, `rvalid` is the write acknowledge and `rdata[p]` is unchanged.

Write/read ordering:
- A write granted in cycle t is visible to any read granted in cycle t+1 or later.
- Same-cycle read/write conflicts cannot occur (single grant per cycle).

Reset:
- Clears `ptr`, `gnt`, `rvalid`, `err`, `rdata` and the in-flight register.
- RAM contents are not cleared.

## Timing
Reset values:
- `gnt` = 0, `rvalid` = 0, `err` = 0, all `rdata` = 0.
- `ptr` = 0.
- `busy` = OR of `req` (combinational).

Latency and throughput:
- `gnt` is combinational from `req`/`ptr`, in the same cycle as the request.
- Fixed latency of one cycle from `gnt` to `rvalid`.
- Throughput is one access per cycle.

Fairness:
- With all four `req` held high, grants cycle 0,1,2,3,0,…
- Worst-case wait is N_PORTS−1 cycles after `req` rises.

Corner cases:
- `rst` high in cycle t: `gnt` is forced to 0 and no write commits. An access granted in cycle t−1 has its `rvalid`/`err` suppressed in cycle t.
- Single requester held continuously: granted every cycle. `ptr` wraps 3→0 without a bubble.
- `req` dropped before grant: no grant and no side effects; `ptr` is unchanged.
- Address 0x1FFF is in range. Address 0x2000 is out of range and sets `err`.

## Structure
Package `mem_arb_pkg`:
- Constants `N_PORTS`, `AW`, `DW`.
- Port indices `PORT_SPI`=0, `PORT_CPU`=3.
- Helper function `rr_pick(req, ptr)` returning the index and a found flag.

Sub-module `word_ram`:
- 2^AW × DW, single port.
- Synchronous write; registered read-first output with 1-cycle latency.
- Maps onto block RAM.

The arbiter itself holds `ptr`, the in-flight register `{valid, port, we, oob}`, and the per-port `rdata` holding registers.

## Test plan
1. Reset, then port 0 writes 0x1234 to 0x0005 and in the next cycle reads 0x0005 → `gnt[0]` in both cycles; second `rvalid[0]` with `rdata[0]`=0x1234 and `err`=0.
2. All four `req` high continuously, all reads → `gnt` sequence 1,2,4,8,1,… (one-hot); each `rvalid` exactly one cycle after its `gnt`.
3. Port 3 reads 0x2000 → `rvalid[3]`=1, `err[3]`=1, `rdata[3]`=0x0000. Memory at 0x0000 is unchanged (verified by a later read).
4. Port 1 writes 0xBEEF to 0x1FFF while port 2 requests a read of 0x1FFF in the same cycle → port 1 is granted first; port 2 is granted the next cycle and reads 0xBEEF.
5. `rst` asserted in the cycle after a port 0 read grant → no `rvalid[0]`, `rdata[0]`=0, `ptr`=0. The first post-reset requests from ports 2 and 0 grant port 0 first.
6. Port 3 write and port 0 read alternating for 100 random cycles → scoreboard matches all `rdata`, and no port waits more than 3 cycles.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared constants, types and the round-robin pick helper for the memory arbiter.
// Contents: port count, RAM geometry, named port indices, grant pick result,
// and the in-flight access record carried from grant to completion.
package mem_arb_pkg;

  localparam int unsigned N_PORTS = 4;
  localparam int unsigned AW      = 13;
  localparam int unsigned DW      = 16;
  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned PW      = $clog2(N_PORTS);

  localparam logic [PW-1:0] PORT_SPI = PW'(0);
  localparam logic [PW-1:0] PORT_CPU = PW'(3);

  typedef struct packed {
    logic          found;
    logic [PW-1:0] idx;
  } pick_t;

  typedef struct packed {
    logic          valid;
    logic [PW-1:0] port;
    logic          we;
    logic          oob;
  } inflight_t;

  // First requesting port at or above ptr, wrapping modulo N_PORTS.
  function automatic pick_t rr_pick(input logic [N_PORTS-1:0] req,
                                    input logic [PW-1:0]      ptr);
    pick_t         res;
    logic [PW-1:0] cand;
    res = '0;
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      cand = PW'((32'(ptr) + i) % N_PORTS);
      if (!res.found && req[cand]) begin
        res.found = 1'b1;
        res.idx   = cand;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester bus shared by all ports of the memory arbiter.
// master: requester side drives req/we/addr/wdata, sees gnt/rvalid/rdata/err/busy.
// slave:  arbiter side.
interface mem_arbiter_if;
  import mem_arb_pkg::*;

  logic [N_PORTS-1:0]        req;
  logic [N_PORTS-1:0]        we;
  logic [N_PORTS*ADDR_W-1:0] addr;
  logic [N_PORTS*DW-1:0]     wdata;
  logic [N_PORTS-1:0]        gnt;
  logic [N_PORTS-1:0]        rvalid;
  logic [N_PORTS*DW-1:0]     rdata;
  logic [N_PORTS-1:0]        err;
  logic                      busy;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata, err, busy
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata, err, busy
  );
endinterface

// File: rtl/mem_arbiter_word_ram.sv
// Single-port 2^AW x DW word RAM, synchronous write, registered read-first output.
// Ports: clk, we (write enable), addr (word address), wdata, rdata (valid the
// cycle after addr is presented; returns the pre-write contents on a write).
module word_ram
  import mem_arb_pkg::*;
#(
  parameter int unsigned RAM_AW = AW,
  parameter int unsigned RAM_DW = DW
) (
  input  logic              clk,
  input  logic              we,
  input  logic [RAM_AW-1:0] addr,
  input  logic [RAM_DW-1:0] wdata,
  output logic [RAM_DW-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << RAM_AW;

  logic [RAM_DW-1:0] mem [DEPTH];
  logic [RAM_DW-1:0] rdata_q;

  // No reset on storage or output so this maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata_q <= mem[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one word RAM among N_PORTS requesters.
// Ports: clk, rst (synchronous, active-high), bus (mem_arbiter_if.slave):
//   req/we/addr/wdata per port in; gnt (same-cycle, combinational) out;
//   rvalid/err one cycle after gnt; rdata held per port until its next read;
//   busy while any request is pending or an access is in flight.
module mem_arbiter
  import mem_arb_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  pick_t                       pick;
  logic                        grant;
  logic [ADDR_W-1:0]           sel_addr;
  logic [DW-1:0]               sel_wdata;
  logic                        sel_we;
  logic                        sel_oob;
  logic                        ram_we;
  logic [DW-1:0]               ram_rdata;

  logic [PW-1:0]               ptr_q, ptr_d;
  inflight_t                   infl_q, infl_d;
  logic [N_PORTS-1:0][DW-1:0]  hold_q, hold_d;

  logic [N_PORTS-1:0]          gnt_c;
  logic [N_PORTS-1:0]          rvalid_c;
  logic [N_PORTS-1:0]          err_c;

  // Grant selection and access issue for the winning port.
  always_comb begin
    pick      = rr_pick(bus.req, ptr_q);
    grant     = pick.found & ~rst;
    sel_addr  = bus.addr[32'(pick.idx) * ADDR_W +: ADDR_W];
    sel_wdata = bus.wdata[32'(pick.idx) * DW +: DW];
    sel_we    = bus.we[pick.idx];
    sel_oob   = |sel_addr[ADDR_W-1:AW];

    gnt_c = '0;
    if (grant) begin
      gnt_c[pick.idx] = 1'b1;
    end

    ram_we = grant & sel_we & ~sel_oob;
    ptr_d  = grant ? PW'(pick.idx + 1'b1) : ptr_q;

    infl_d       = '0;
    infl_d.valid = grant;
    infl_d.port  = pick.idx;
    infl_d.we    = sel_we;
    infl_d.oob   = sel_oob;
  end

  // Completion: RAM output is valid the cycle after grant; reset suppresses it.
  always_comb begin
    rvalid_c = '0;
    err_c    = '0;
    hold_d   = hold_q;
    if (infl_q.valid && !rst) begin
      rvalid_c[infl_q.port] = 1'b1;
      err_c[infl_q.port]    = infl_q.oob;
      if (!infl_q.we) begin
        hold_d[infl_q.port] = infl_q.oob ? '0 : ram_rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q  <= '0;
      infl_q <= '0;
      hold_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      infl_q <= infl_d;
      hold_q <= hold_d;
    end
  end

  word_ram u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (sel_addr[AW-1:0]),
    .wdata (sel_wdata),
    .rdata (ram_rdata)
  );

  // hold_d shows fresh read data in the completion cycle and keeps it afterwards.
  assign bus.gnt    = gnt_c;
  assign bus.rvalid = rvalid_c;
  assign bus.err    = err_c;
  assign bus.rdata  = rst ? '0 : hold_d;
  assign bus.busy   = (|bus.req) | infl_q.valid;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed/random bench for mem_arbiter with a completion scoreboard and memory model.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic clk;
  logic rst;

  mem_arbiter_if bus ();

  mem_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
  } txn_t;

  typedef struct packed {
    logic [1:0]  port;
    logic        we;
    logic        err;
    logic [15:0] rdata;
  } exp_t;

  txn_t        pq [N_PORTS][$];
  exp_t        sb [$];
  logic [15:0] mem_m [8192];
  logic [15:0] rd_m  [N_PORTS];
  int          m_ptr;
  int          wait_c [N_PORTS];
  int          vectors;
  int          miscompares;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int p = 0; p < int'(N_PORTS); p++) begin
      if (pq[p].size() > 0) begin
        bus.req[p]             = 1'b1;
        bus.we[p]              = pq[p][0].we;
        bus.addr[p*16 +: 16]   = pq[p][0].addr;
        bus.wdata[p*16 +: 16]  = pq[p][0].wdata;
      end else begin
        bus.req[p]             = 1'b0;
        bus.we[p]              = 1'b0;
        bus.addr[p*16 +: 16]   = 16'h0;
        bus.wdata[p*16 +: 16]  = 16'h0;
      end
    end
  endtask

  task automatic model_reset();
    sb.delete();
    m_ptr = 0;
    for (int p = 0; p < int'(N_PORTS); p++) begin
      rd_m[p]   = 16'h0;
      wait_c[p] = 0;
    end
  endtask

  // One clock: check completion of the previous grant, then this cycle's grant.
  task automatic step();
    exp_t                  e;
    txn_t                  t;
    logic [N_PORTS-1:0]    exp_rv, exp_err, exp_gnt;
    logic [N_PORTS*16-1:0] exp_rd;
    logic                  inflight;
    int                    g;
    drive();
    #2;
    exp_rv   = '0;
    exp_err  = '0;
    inflight = (sb.size() != 0);
    if (inflight) begin
      e = sb.pop_front();
      exp_rv[e.port]  = 1'b1;
      exp_err[e.port] = e.err;
      if (!e.we) rd_m[e.port] = e.rdata;
    end
    for (int p = 0; p < int'(N_PORTS); p++) exp_rd[p*16 +: 16] = rd_m[p];
    chk("rvalid", 64'(bus.rvalid), 64'(exp_rv));
    chk("err", 64'(bus.err), 64'(exp_err));
    chk("rdata", 64'(bus.rdata), 64'(exp_rd));
    chk("busy", 64'(bus.busy), 64'((|bus.req) | inflight));

    // Nearest requesting port at or after the model pointer.
    g = -1;
    for (int k = int'(N_PORTS) - 1; k >= 0; k--) begin
      if (bus.req[(m_ptr + k) % int'(N_PORTS)]) g = (m_ptr + k) % int'(N_PORTS);
    end
    exp_gnt = '0;
    if (g >= 0) exp_gnt[g] = 1'b1;
    chk("gnt", 64'(bus.gnt), 64'(exp_gnt));

    for (int p = 0; p < int'(N_PORTS); p++) begin
      if (bus.req[p] && p != g) wait_c[p]++;
    end
    if (g >= 0) begin
      chk("wait_le_3", 64'(wait_c[g] <= 3), 64'(1));
      wait_c[g] = 0;
      t        = pq[g].pop_front();
      e.port   = 2'(g);
      e.we     = t.we;
      e.err    = (t.addr >= 16'h2000);
      e.rdata  = e.err ? 16'h0 : mem_m[t.addr[12:0]];
      if (t.we && !e.err) mem_m[t.addr[12:0]] = t.wdata;
      sb.push_back(e);
      m_ptr = (g + 1) % int'(N_PORTS);
    end
    @(posedge clk);
    #1;
  endtask

  function automatic int pending();
    int n = sb.size();
    for (int p = 0; p < int'(N_PORTS); p++) n += pq[p].size();
    return n;
  endfunction

  task automatic run(input int max_cycles);
    int n = 0;
    while (pending() != 0 && n < max_cycles) begin
      step();
      n++;
    end
    chk("drain", 64'(pending()), 64'(0));
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    bus.req     = '0;
    bus.we      = '0;
    bus.addr    = '0;
    bus.wdata   = '0;
    model_reset();
    @(posedge clk);
    #1;
    @(posedge clk);
    #3;
    chk("rst_gnt", 64'(bus.gnt), 64'(0));
    chk("rst_rvalid", 64'(bus.rvalid), 64'(0));
    chk("rst_err", 64'(bus.err), 64'(0));
    chk("rst_busy", 64'(bus.busy), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_rdata", 64'(bus.rdata), 64'(0));

    // 1: write then back-to-back read on port 0
    pq[0].push_back('{1'b1, 16'h0005, 16'h1234});
    pq[0].push_back('{1'b0, 16'h0005, 16'h0000});
    run(10);

    // 2: port 3 fills 0x10..0x13, then all four ports read continuously
    for (int k = 0; k < 4; k++) pq[3].push_back('{1'b1, 16'h0010 + 16'(k), 16'hA000 + 16'(k)});
    run(10);
    for (int r = 0; r < 3; r++)
      for (int p = 0; p < 4; p++) pq[p].push_back('{1'b0, 16'h0010 + 16'((p + r) % 4), 16'h0});
    run(20);

    // 3: out-of-range write and read on port 3 must not alias address 0
    pq[0].push_back('{1'b1, 16'h0000, 16'h5A5A});
    run(5);
    pq[3].push_back('{1'b1, 16'h2000, 16'hDEAD});
    pq[3].push_back('{1'b0, 16'h2000, 16'h0000});
    run(6);
    pq[0].push_back('{1'b0, 16'h0000, 16'h0000});
    run(5);

    // 4: top in-range address; same-cycle write (port 1) and read (port 2)
    pq[1].push_back('{1'b1, 16'h1FFF, 16'hBEEF});
    pq[2].push_back('{1'b0, 16'h1FFF, 16'h0000});
    run(6);

    // 5: reset right after a port 0 read grant
    pq[0].push_back('{1'b0, 16'h0005, 16'h0000});
    step();
    rst       = 1'b1;
    bus.req   = 4'b0101;
    bus.we    = 4'b0001;
    bus.addr  = {16'h0, 16'h0005, 16'h0, 16'h0005};
    bus.wdata = {16'h0, 16'h0, 16'h0, 16'hFFFF};
    #2;
    chk("rst_cycle_gnt", 64'(bus.gnt), 64'(0));
    chk("rst_cycle_rvalid", 64'(bus.rvalid), 64'(0));
    chk("rst_cycle_err", 64'(bus.err), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    pq[2].push_back('{1'b0, 16'h0005, 16'h0000});
    pq[0].push_back('{1'b0, 16'h0005, 16'h0000});
    run(6);

    // 6: random port 3 writes and port 0 reads over a small address window
    for (int k = 0; k < 8; k++) pq[3].push_back('{1'b1, 16'h0040 + 16'(k), 16'($urandom)});
    run(20);
    for (int i = 0; i < 100; i++) begin
      if (pq[3].size() == 0 && $urandom_range(0, 1) == 1)
        pq[3].push_back('{1'b1, 16'h0040 + 16'($urandom_range(0, 7)), 16'($urandom)});
      if (pq[0].size() == 0 && $urandom_range(0, 1) == 1)
        pq[0].push_back('{1'b0, 16'h0040 + 16'($urandom_range(0, 7)), 16'h0});
      step();
    end
    run(20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
